ascii_stream_validator: RTL and testbench
=========================================

Name: ascii_stream_validator

Overview:
- Streaming successor to the payload character validator. Sits between uart_packet_handler and the number separator.
- Validates each payload byte against a configurable character class and forwards bytes downstream through an internal FIFO, instead of exposing a full-payload array.
- Reports length, the first invalid position and overflow.
- Re-arms for the next packet on a done acknowledge, instead of latching DONE until reset.

Parameters:
- MAX_PAYLOAD, 2048, maximum number of bytes forwarded per packet.
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 2.
- ALLOW_SEP, 0, 1 = also accept comma 0x2C, CR 0x0D and LF 0x0A.
- LEN_W, $clog2(MAX_PAYLOAD+1), width of the length and position outputs.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- payload_data  in  8  input byte.
- payload_valid  in  1  input byte valid.
- payload_last  in  1  final byte of the packet.
- payload_ready  out  1  input accept.
- out_data  out  8  forwarded byte.
- out_valid  out  1  forwarded byte valid.
- out_last  out  1  final forwarded byte of the packet.
- out_ready  in  1  downstream accept.
- done  out  1  packet complete and FIFO drained.
- done_ack  in  1  release status, return to IDLE.
- invalid  out  1  at least one illegal byte seen.
- err_pos  out  LEN_W  0-based index of the first illegal byte; 0 when invalid=0.
- overflow  out  1  packet was longer than MAX_PAYLOAD.
- length  out  LEN_W  bytes forwarded; saturates at MAX_PAYLOAD.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE. Reset mid-packet discards the FIFO contents and all status immediately.
- Character class:
  - Always legal: 0x30-0x39, 0x20, 0x2D.
  - Also legal when ALLOW_SEP=1: 0x2C, 0x0D, 0x0A.
  - Illegal bytes are still forwarded unchanged; only the status flags them.
- Handshakes: a transfer occurs when valid && ready is high at a rising clk edge, on both sides.
- States:
  - IDLE / RECV: payload_ready = !fifo_full. A byte accepted in IDLE moves to RECV and is processed identically to a byte accepted in RECV.
  - DROP: payload_ready = 1. Bytes are consumed and discarded; length, invalid and err_pos are frozen.
  - FLUSH: payload_ready = 0. Waits for the FIFO to empty.
  - DONE: payload_ready = 0. done = 1.
- Index counter: counts accepted bytes from 0.
  - On each accepted, forwarded byte: push {byte, tag}, then index+1 and length+1.
  - On the first illegal byte: invalid = 1, err_pos = index. Later illegal bytes do not move err_pos.
- Last-byte tagging:
  - Accepted byte with payload_last = 1: tag = 1, next state FLUSH.
  - Accepted byte with index == MAX_PAYLOAD-1 and payload_last = 0: tag forced to 1, overflow = 1, next state DROP.
  - That same byte with payload_last = 1 instead: normal completion, overflow = 0.
- DROP exits to FLUSH on the accepted byte with payload_last = 1.
- FLUSH -> DONE in the cycle after the FIFO becomes empty, i.e. after the tagged entry has been popped.
- DONE -> IDLE on done_ack = 1. Leaving DONE clears invalid, err_pos, overflow, length and index. done_ack is ignored in every other state.
- Latency:
  - A byte accepted at edge N is presented on out_valid/out_data after edge N (registered FIFO read, no combinational input-to-output path).
  - Throughput is 1 byte/cycle with out_ready held high.
  - The FIFO supports push and pop in the same cycle. A full FIFO deasserts payload_ready in the following cycle (registered full flag).
- Status outputs (invalid, err_pos, overflow, length) update one cycle after the accepting edge and are stable throughout FLUSH and DONE.
- payload_valid in FLUSH or DONE is not accepted. The upstream holds the byte until IDLE.
- Back-to-back packets: the first byte of the next packet is accepted in IDLE the cycle after done_ack.

Test Plan:
- "12 -3" (5 bytes, last on '3'), out_ready = 1:
  - out stream equals input with out_last on 0x33.
  - done = 1, length = 5, invalid = 0, overflow = 0.
  - done_ack returns to IDLE and status reads 0.
- "1a2b" with ALLOW_SEP = 0: invalid = 1, err_pos = 1, length = 4, all 4 bytes forwarded. Repeat "1,2" with ALLOW_SEP = 1: invalid = 0.
- MAX_PAYLOAD = 8, 11-byte packet:
  - 8 bytes forwarded, out_last on byte 8.
  - Bytes 9-11 consumed.
  - overflow = 1, length = 8.
  - Exact 8-byte packet gives overflow = 0.
- FIFO_DEPTH = 4, out_ready = 0, 10-byte packet:
  - payload_ready drops after 4 accepts.
  - Releasing out_ready streams all 10 in order.
  - done is asserted only after the final pop.
- Reset pulse mid-packet after 3 bytes:
  - All outputs 0 and FIFO empty on the same edge.
  - A fresh packet "7" gives length = 1, done = 1.
- done_ack pulsed during FLUSH: ignored. done still rises, then IDLE after an ack issued in DONE.

Source files
------------

// File: rtl/ascii_stream_validator.sv
// Streaming payload validator: checks each byte against a character class,
// forwards it through a small output FIFO and reports length/error/overflow status.
module ascii_stream_validator #(
   parameter int unsigned MAX_PAYLOAD = 2048,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter bit          ALLOW_SEP   = 1'b0,
   parameter int unsigned LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       payload_data,
   input  logic             payload_valid,
   input  logic             payload_last,
   output logic             payload_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic             done,
   input  logic             done_ack,
   output logic             invalid,
   output logic [LEN_W-1:0] err_pos,
   output logic             overflow,
   output logic [LEN_W-1:0] length
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RECV  = 3'd1;
   localparam logic [2:0] S_DROP  = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state, state_nxt;
   logic [8:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt, wr_ptr;
   logic [CNT_W-1:0] cnt, cnt_kept, cnt_nxt;
   logic             accept, push, pop, tag, at_limit, rearm, legal;
   logic [8:0]       head_nxt;

   // Character class of the incoming byte
   always_comb begin
      legal = ((payload_data >= 8'h30) && (payload_data <= 8'h39)) ||
              (payload_data == 8'h20) || (payload_data == 8'h2D);
      if (ALLOW_SEP) begin
         legal = legal || (payload_data == 8'h2C) ||
                 (payload_data == 8'h0D) || (payload_data == 8'h0A);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state, FIFO push decision and last-byte tagging
   always_comb begin
      state_nxt = state;
      accept    = payload_valid && payload_ready;
      push      = 1'b0;
      tag       = payload_last;
      rearm     = 1'b0;
      at_limit  = (length == LEN_W'(MAX_PAYLOAD - 1));
      case (state)
         S_IDLE, S_RECV: begin
            if (accept) begin
               push = 1'b1;
               if (payload_last) begin
                  state_nxt = S_FLUSH;
               end else if (at_limit) begin
                  tag       = 1'b1;
                  state_nxt = S_DROP;
               end else begin
                  state_nxt = S_RECV;
               end
            end
         end
         S_DROP:  if (accept && payload_last) state_nxt = S_FLUSH;
         S_FLUSH: if (cnt == '0) state_nxt = S_DONE;
         S_DONE: begin
            if (done_ack) begin
               state_nxt = S_IDLE;
               rearm     = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // FIFO bookkeeping; the head entry is pre-selected for the output register
   always_comb begin
      pop        = out_valid && out_ready;
      rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
      cnt_kept   = pop ? cnt - CNT_W'(1) : cnt;
      cnt_nxt    = push ? cnt_kept + CNT_W'(1) : cnt_kept;
      head_nxt   = (push && (cnt_kept == '0)) ? {payload_data, tag} : mem[rd_ptr_nxt];
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {payload_data, tag};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         cnt           <= '0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_last      <= 1'b0;
         payload_ready <= 1'b0;
         done          <= 1'b0;
      end else begin
         rd_ptr        <= rd_ptr_nxt;
         cnt           <= cnt_nxt;
         out_valid     <= (cnt_nxt != '0);
         {out_data, out_last} <= head_nxt;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         payload_ready <= (state_nxt == S_DROP) ||
                          (((state_nxt == S_IDLE) || (state_nxt == S_RECV)) &&
                           (cnt_nxt != CNT_W'(FIFO_DEPTH)));
         done          <= (state_nxt == S_DONE);
      end
   end

   // Packet status; frozen once the packet stops forwarding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         length   <= '0;
         invalid  <= 1'b0;
         err_pos  <= '0;
         overflow <= 1'b0;
      end else if (rearm) begin
         length   <= '0;
         invalid  <= 1'b0;
         err_pos  <= '0;
         overflow <= 1'b0;
      end else if (push) begin
         length <= length + LEN_W'(1);
         if (!legal && !invalid) begin
            invalid <= 1'b1;
            err_pos <= length;
         end
         if (at_limit && !payload_last) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ascii_stream_validator.sv
// Randomized scoreboard bench for ascii_stream_validator with a packet-level reference model.
`timescale 1ns/1ps
module tb_ascii_stream_validator;

   localparam int unsigned MAX_PAYLOAD = 8;
   localparam int unsigned FIFO_DEPTH  = 4;
   localparam bit          ALLOW_SEP   = 1'b1;
   localparam int unsigned LEN_W       = $clog2(MAX_PAYLOAD + 1);
   localparam int          TO          = 200;

   typedef logic [7:0] pkt_t [$];

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       payload_data = '0;
   logic             payload_valid = 1'b0;
   logic             payload_last = 1'b0;
   logic             payload_ready;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_last;
   logic             out_ready = 1'b0;
   logic             done;
   logic             done_ack = 1'b0;
   logic             invalid;
   logic [LEN_W-1:0] err_pos;
   logic             overflow;
   logic [LEN_W-1:0] length;

   int         checks = 0;
   int         errors = 0;
   int         accepts = 0;
   int         rdy_mode = 1;
   logic [8:0] exp_q [$];
   int         exp_len, exp_pos;
   bit         exp_inv, exp_ovf;

   ascii_stream_validator #(
      .MAX_PAYLOAD(MAX_PAYLOAD), .FIFO_DEPTH(FIFO_DEPTH), .ALLOW_SEP(ALLOW_SEP), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .payload_data(payload_data), .payload_valid(payload_valid),
      .payload_last(payload_last), .payload_ready(payload_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .done(done), .done_ack(done_ack), .invalid(invalid), .err_pos(err_pos),
      .overflow(overflow), .length(length)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Downstream ready pattern: 0 = held low, 1 = held high, 2 = random
   always begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Monitor: pops the scoreboard on every output transfer
   always @(negedge clk) begin
      if (rst_n && payload_valid && payload_ready) accepts++;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_extra: got byte %0h last %0b with nothing expected", out_data, out_last);
         end else begin
            check("out_stream", 32'({out_data, out_last}), 32'(exp_q.pop_front()));
         end
      end
   end

   function automatic bit is_legal(input logic [7:0] b);
      string s;
      if (ALLOW_SEP) s = "0123456789 -,\r\n";
      else           s = "0123456789 -";
      for (int i = 0; i < s.len(); i++) if (s[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   function automatic pkt_t str2pkt(input string s);
      pkt_t p;
      for (int i = 0; i < s.len(); i++) p.push_back(s[i]);
      return p;
   endfunction

   // Reference model: forwarded prefix, status and expected output stream
   task automatic load_model(input pkt_t pkt);
      int n, fwd;
      n       = pkt.size();
      fwd     = (n > int'(MAX_PAYLOAD)) ? int'(MAX_PAYLOAD) : n;
      exp_len = fwd;
      exp_ovf = (n > int'(MAX_PAYLOAD));
      exp_inv = 1'b0;
      exp_pos = 0;
      for (int i = 0; i < fwd; i++) begin
         if (!is_legal(pkt[i]) && !exp_inv) begin
            exp_inv = 1'b1;
            exp_pos = i;
         end
         exp_q.push_back({pkt[i], (i == fwd - 1)});
      end
   endtask

   task automatic drive_byte(input logic [7:0] b, input logic l);
      int cyc = 0;
      payload_data  = b;
      payload_last  = l;
      payload_valid = 1'b1;
      @(negedge clk);
      while (!payload_ready && cyc < TO) begin
         @(negedge clk);
         cyc++;
      end
      if (!payload_ready) check("accept_timeout", 32'(payload_ready), 32'd1);
      @(posedge clk);
      #1;
      payload_valid = 1'b0;
      payload_last  = 1'b0;
   endtask

   task automatic send_packet(input pkt_t pkt);
      load_model(pkt);
      @(posedge clk);
      #1;
      for (int i = 0; i < pkt.size(); i++) drive_byte(pkt[i], (i == pkt.size() - 1));
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      @(negedge clk);
      while (!done && cyc < TO) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_done"}, 32'(done), 32'd1);
      if (done) begin
         check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
         check({name, "_out_idle"}, 32'(out_valid), 32'd0);
         check({name, "_length"}, 32'(length), 32'(exp_len));
         check({name, "_invalid"}, 32'(invalid), 32'(exp_inv));
         check({name, "_err_pos"}, 32'(err_pos), 32'(exp_pos));
         check({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
      end
   endtask

   task automatic ack_done(input string name);
      @(posedge clk);
      #1 done_ack = 1'b1;
      @(posedge clk);
      #1 done_ack = 1'b0;
      @(negedge clk);
      check({name, "_ack_done"}, 32'(done), 32'd0);
      check({name, "_ack_status"}, 32'({invalid, overflow, err_pos, length}), 32'd0);
      check({name, "_ack_ready"}, 32'(payload_ready), 32'd1);
   endtask

   task automatic check_zero(input string name);
      check({name, "_out"}, 32'({out_valid, out_last, out_data}), 32'd0);
      check({name, "_ctl"}, 32'({payload_ready, done}), 32'd0);
      check({name, "_status"}, 32'({invalid, overflow, err_pos, length}), 32'd0);
   endtask

   task automatic run_packet(input string name, input pkt_t pkt);
      send_packet(pkt);
      wait_done(name);
      ack_done(name);
   endtask

   initial begin
      pkt_t p;
      int   a0;

      #22;
      check_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      rdy_mode = 1;
      run_packet("basic", str2pkt("12 -3"));
      run_packet("alpha", str2pkt("1a2b"));
      run_packet("sep", str2pkt("1,2"));
      run_packet("ovf11", str2pkt("12345678901"));
      run_packet("exact8", str2pkt("87654321"));

      // Backpressure: FIFO fills, then drains in order
      rdy_mode = 0;
      a0 = accepts;
      fork
         send_packet(str2pkt("0123456789"));
         begin
            repeat (20) @(negedge clk);
            check("fifo_accepts", 32'(accepts - a0), 32'(FIFO_DEPTH));
            check("fifo_ready_low", 32'(payload_ready), 32'd0);
            check("fifo_no_done", 32'(done), 32'd0);
            rdy_mode = 1;
         end
      join
      wait_done("fifo");
      ack_done("fifo");

      // Reset in the middle of a packet
      p = str2pkt("123");
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({p[i], 1'b0});
         drive_byte(p[i], 1'b0);
      end
      #2 rst_n = 1'b0;
      #1;
      check_zero("midreset");
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_packet("fresh", str2pkt("7"));

      // done_ack during FLUSH is ignored
      rdy_mode = 0;
      send_packet(str2pkt("55"));
      @(posedge clk);
      #1 done_ack = 1'b1;
      @(posedge clk);
      #1 done_ack = 1'b0;
      @(negedge clk);
      check("flush_ack_done", 32'(done), 32'd0);
      check("flush_ack_pending", 32'(out_valid), 32'd1);
      rdy_mode = 1;
      wait_done("flush_ack");
      ack_done("flush_ack");

      // Randomized packets with random downstream backpressure
      rdy_mode = 2;
      for (int k = 0; k < 30; k++) begin
         int n;
         pkt_t rp;
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4, 5: rp.push_back(8'(8'h30 + $urandom_range(0, 9)));
               6:                rp.push_back(($urandom_range(0, 1) != 0) ? 8'h20 : 8'h2D);
               7: begin
                  case ($urandom_range(0, 2))
                     0:       rp.push_back(8'h2C);
                     1:       rp.push_back(8'h0D);
                     default: rp.push_back(8'h0A);
                  endcase
               end
               8:       rp.push_back(8'($urandom_range(0, 255)));
               default: rp.push_back(8'(8'h61 + $urandom_range(0, 25)));
            endcase
         end
         run_packet("rand", rp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
